// File: rtl/logic_pipe_pkg.sv
// Shared types and default sizing for the multi-function logic pipeline.
package logic_pipe_pkg;

   localparam int unsigned LP_WIDTH_DEF = 8;
   localparam int unsigned LP_CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      MODE_ANDNOT_OR = 2'd0,
      MODE_XOR_ORN   = 2'd1,
      MODE_AND3      = 2'd2,
      MODE_OR3       = 2'd3
   } mode_e;

endpackage

// File: rtl/logic_pipe_func.sv
// Combinational bitwise function unit selected by mode.
module logic_pipe_func
   import logic_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = LP_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   input  mode_e            mode_i,
   output logic [WIDTH-1:0] q_o
);

   // Per-bit function select
   always_comb begin
      q_o = '0;
      case (mode_i)
         MODE_ANDNOT_OR: q_o = (~a_i & b_i) | c_i;
         MODE_XOR_ORN:   q_o = (a_i ^ b_i) | ~c_i;
         MODE_AND3:      q_o = a_i & b_i & c_i;
         MODE_OR3:       q_o = a_i | b_i | c_i;
         default:        q_o = '0;
      endcase
   end

endmodule

// File: rtl/multi_func_logic_pipe.sv
// Two-stage valid/ready pipeline around logic_pipe_func, with a completed
// output-transfer counter. Optional macro LOGIC_PIPE_POPCOUNT_EN adds out_ones,
// the registered count of 1 bits in out_q.
module multi_func_logic_pipe
   import logic_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = LP_WIDTH_DEF,
   parameter int unsigned CNT_W = LP_CNT_W_DEF
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   input  logic [1:0]       in_mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count
`ifdef LOGIC_PIPE_POPCOUNT_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] out_ones
`endif
);

   // Stage 1 holding registers
   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   logic [WIDTH-1:0] s1_c_q;
   mode_e            s1_mode_q;

   // Stage 2 / output registers
   logic             s2_valid_q;
   logic [WIDTH-1:0] s2_res_q;
   logic [WIDTH-1:0] s2_res_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   logic s1_rdy;
   logic s2_rdy;
   logic in_xfer;
   logic out_xfer;

   // Handshake: each stage is ready when empty or when the next one advances
   always_comb begin
      s2_rdy   = ~s2_valid_q | out_ready;
      s1_rdy   = ~s1_valid_q | s2_rdy;
      in_xfer  = in_valid & s1_rdy;
      out_xfer = s2_valid_q & out_ready;
      count_d  = out_xfer ? count_q + CNT_W'(1) : count_q;
   end

   logic_pipe_func #(
      .WIDTH(WIDTH)
   ) u_func (
      .a_i   (s1_a_q),
      .b_i   (s1_b_q),
      .c_i   (s1_c_q),
      .mode_i(s1_mode_q),
      .q_o   (s2_res_d)
   );

   // Stage 1: capture operands and mode on an input transfer
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_c_q     <= '0;
         s1_mode_q  <= MODE_ANDNOT_OR;
      end else if (s1_rdy) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_a_q    <= in_a;
            s1_b_q    <= in_b;
            s1_c_q    <= in_c;
            s1_mode_q <= mode_e'(in_mode);
         end
      end
   end

   // Stage 2: register the computed result; hold while stalled
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
      end else if (s2_rdy) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_res_q <= s2_res_d;
         end
      end
   end

   // Completed output-transfer counter, wraps naturally
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign in_ready  = s1_rdy;
   assign out_valid = s2_valid_q;
   assign out_q     = s2_res_q;
   assign out_count = count_q;

`ifdef LOGIC_PIPE_POPCOUNT_EN
   localparam int unsigned ONES_W = $clog2(WIDTH + 1);

   logic [ONES_W-1:0] ones_d;
   logic [ONES_W-1:0] ones_q;

   // Population count of the result entering stage 2
   always_comb begin
      ones_d = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         ones_d = ones_d + ONES_W'(s2_res_d[i]);
      end
   end

   // Registered alongside the stage-2 result with the same enables
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         ones_q <= '0;
      end else if (s2_rdy && s1_valid_q) begin
         ones_q <= ones_d;
      end
   end

   assign out_ones = ones_q;
`endif

endmodule

// File: tb/tb_multi_func_logic_pipe.sv
// Self-checking bench for multi_func_logic_pipe (WIDTH=4, CNT_W=4).
module tb_multi_func_logic_pipe;

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 4;

   logic          in_clk;
   logic          in_rst;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [W-1:0]  in_c;
   logic [1:0]    in_mode;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_q;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_count;
`ifdef LOGIC_PIPE_POPCOUNT_EN
   logic [2:0]    out_ones;
`endif

   int errors = 0;
   int checks = 0;
   bit cmp_en = 0;

   multi_func_logic_pipe #(
      .WIDTH(W),
      .CNT_W(CW)
   ) dut (
      .in_clk   (in_clk),
      .in_rst   (in_rst),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_c     (in_c),
      .in_mode  (in_mode),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_q    (out_q),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_count(out_count)
`ifdef LOGIC_PIPE_POPCOUNT_EN
      ,
      .out_ones (out_ones)
`endif
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   function automatic logic [W-1:0] ref_f(logic [W-1:0] a, logic [W-1:0] b,
                                          logic [W-1:0] c, logic [1:0] m);
      case (m)
         2'd0:    return (~a & b) | c;
         2'd1:    return (a ^ b) | ~c;
         2'd2:    return a & b & c;
         default: return a | b | c;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic rand_ops();
      in_a    = W'($urandom);
      in_b    = W'($urandom);
      in_c    = W'($urandom);
      in_mode = 2'($urandom);
   endtask

   // Reference model: ordered list of in-flight transactions, each tagged with
   // how far it has travelled (1 = just accepted, 2 = presented at the output).
   typedef struct {
      logic [W-1:0] q;
      int           stage;
   } item_t;

   item_t  mq[$];
   int     mcount = 0;
   bit     exp_rdy;
   bit     exp_vld;
   item_t  tmp;

   always @(negedge in_clk) begin
      exp_rdy = !(mq.size() == 2 && !out_ready);
      exp_vld = (mq.size() > 0) && (mq[0].stage == 2);
      if (cmp_en) begin
         check("in_ready", in_ready, exp_rdy);
         check("out_valid", out_valid, exp_vld);
         if (exp_vld) begin
            check("out_q", out_q, mq[0].q);
`ifdef LOGIC_PIPE_POPCOUNT_EN
            check("out_ones", out_ones, $countones(mq[0].q));
`endif
         end
         check("out_count", out_count, mcount);
      end
      if (in_rst) begin
         mq.delete();
         mcount = 0;
      end else begin
         if (exp_vld && out_ready) begin
            tmp = mq.pop_front();
            mcount = (mcount + 1) % 16;
         end
         if (mq.size() > 0 && mq[0].stage == 1) begin
            tmp = mq.pop_front();
            tmp.stage = 2;
            mq.push_front(tmp);
         end
         if (in_valid && exp_rdy) begin
            tmp.q = ref_f(in_a, in_b, in_c, in_mode);
            tmp.stage = 1;
            mq.push_back(tmp);
         end
      end
   end

   logic [W-1:0] mode_exp [4];
   logic [W-1:0] last_exp;

   initial begin
      mode_exp[0] = 4'b0011;
      mode_exp[1] = 4'b1110;
      mode_exp[2] = 4'b0001;
      mode_exp[3] = 4'b0111;

      // Reset held for two cycles with in_valid asserted
      in_rst    = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      rand_ops();
      step();
      cmp_en = 1;
      step();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_q", out_q, 4'b0000);
      check("rst_out_count", out_count, 4'd0);
`ifdef LOGIC_PIPE_POPCOUNT_EN
      check("rst_out_ones", out_ones, 3'd0);
`endif
      in_rst   = 1'b0;
      in_valid = 1'b0;
      check("ready_after_rst", in_ready, 1'b1);

      // Each mode with fixed operands, result two cycles after input
      for (int m = 0; m < 4; m++) begin
         in_a     = 4'b0101;
         in_b     = 4'b0011;
         in_c     = 4'b0001;
         in_mode  = 2'(m);
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         rand_ops();
         step();
         check("mode_valid", out_valid, 1'b1);
         check("mode_result", out_q, mode_exp[m]);
`ifdef LOGIC_PIPE_POPCOUNT_EN
         check("mode_ones", out_ones, $countones(mode_exp[m]));
`endif
      end
      step();

      // Back-pressure: two accepted then in_ready drops
      out_ready = 1'b0;
      in_valid  = 1'b1;
      rand_ops();
      step();
      rand_ops();
      step();
      rand_ops();
      check("bp_ready_low", in_ready, 1'b0);
      step();
      step();
      check("bp_still_low", in_ready, 1'b0);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // Streaming 20 back-to-back from a clean counter
      in_rst = 1'b1;
      step();
      in_rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rand_ops();
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      check("stream_count_wrap", out_count, 4'd4);
      step();

      // Mid-stream reset with two in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      rand_ops();
      step();
      rand_ops();
      step();
      in_valid = 1'b0;
      check("inflight_valid", out_valid, 1'b1);
      in_rst = 1'b1;
      step();
      in_rst = 1'b0;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_count", out_count, 4'd0);
      out_ready = 1'b1;
      in_a      = 4'b1100;
      in_b      = 4'b1010;
      in_c      = 4'b0110;
      in_mode   = 2'd1;
      in_valid  = 1'b1;
      last_exp  = 4'b1111;
      step();
      in_valid = 1'b0;
      step();
      check("post_rst_result", out_q, last_exp);
      step();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         rand_ops();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_rst    = ($urandom_range(0, 63) == 0);
         step();
      end
      in_rst    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
